// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the load/store stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-addressed data RAM with one outstanding byte/half/word request and fixed response latency.
module dmem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
`ifdef DMEM_INIT_EN
    ,
    parameter string INIT_FILE = "data.txt"
`endif
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt;
    logic          accept, done;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          err;
    logic [31:0]   rd_word, ld_data, wr_data;
    logic [3:0]    wr_mask;
    logic [31:0]   res_p0;
    logic          err_p0;

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign idx     = bus.req_addr[AW+1:2];
    assign off     = bus.req_addr[1:0];
    assign rd_word = mem[idx];
    assign ld_data = extend(rd_word, off, bus.req_size, bus.req_uns);
    assign wr_mask = lane_mask(off, bus.req_size);
    assign err     = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) & off[0])
                   | ((bus.req_size == 2'b10) & (off != 2'b00))
                   | (bus.req_addr[31:2] >= 30'(DEPTH));

    always_comb begin
        case (bus.req_size)
            2'b00:   wr_data = {4{bus.req_wdata[7:0]}};
            2'b01:   wr_data = {2{bus.req_wdata[15:0]}};
            default: wr_data = bus.req_wdata;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        accept        = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                accept        = bus.req_valid;
                if (bus.req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.rsp_valid <= done;
            if (accept)
                cnt <= 2'(LATENCY - 1);
            else if (cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (done) begin
                bus.rsp_rdata <= res_p0;
                bus.rsp_err   <= err_p0;
            end
        end
    end

    // p0: result captured at the accept edge, released when the latency count expires
    always_ff @(posedge clk) begin
        if (accept) begin
            err_p0 <= err;
            res_p0 <= (err | bus.req_we) ? 32'd0 : ld_data;
        end
    end

    // RAM is never reset; erroneous stores leave it untouched
    always_ff @(posedge clk) begin
        if (accept & bus.req_we & ~err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl at LATENCY=1 (u1) and LATENCY=3 (u3).
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v1 = 1'b0, v3 = 1'b0;
    logic        r_we = 1'b0, r_uns = 1'b0;
    logic [1:0]  r_size = 2'b00;
    logic [31:0] r_addr = 32'd0, r_wdata = 32'd0;

    always #5 clk = ~clk;

    dmem_ctrl_if b1 ();
    dmem_ctrl_if b3 ();

    assign b1.req_valid = v1;
    assign b1.req_we    = r_we;
    assign b1.req_size  = r_size;
    assign b1.req_uns   = r_uns;
    assign b1.req_addr  = r_addr;
    assign b1.req_wdata = r_wdata;
    assign b3.req_valid = v3;
    assign b3.req_we    = r_we;
    assign b3.req_size  = r_size;
    assign b3.req_uns   = r_uns;
    assign b3.req_addr  = r_addr;
    assign b3.req_wdata = r_wdata;

    dmem_ctrl #(.DEPTH(64), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_ctrl #(.DEPTH(64), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rv(input bit s);
        return s ? b3.rsp_valid : b1.rsp_valid;
    endfunction
    function automatic logic rr(input bit s);
        return s ? b3.req_ready : b1.req_ready;
    endfunction
    function automatic logic [31:0] rd(input bit s);
        return s ? b3.rsp_rdata : b1.rsp_rdata;
    endfunction
    function automatic logic re(input bit s);
        return s ? b3.rsp_err : b1.rsp_err;
    endfunction

    // One request to u1 (s=0) or u3 (s=1); checks latency, data, error and pulse width
    task automatic req(input bit s, input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        int   lat;
        rsp_t r;
        @(negedge clk);
        check({tag, "/ready"}, 32'(rr(s)), 32'd1);
        r_we = we; r_size = size; r_uns = uns; r_addr = addr; r_wdata = wdata;
        if (s) v3 = 1'b1; else v1 = 1'b1;
        sb.push_back('{exp_rd, exp_err});
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; v3 = 1'b0;
        lat = 0;
        while (!rv(s) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/lat"}, 32'(lat), s ? 32'd3 : 32'd1);
        r = sb.pop_front();
        check({tag, "/rdata"}, rd(s), r.rdata);
        check({tag, "/err"}, 32'(re(s)), 32'(r.err));
        @(negedge clk);
        check({tag, "/pulse"}, 32'(rv(s)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t r;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst/ready1", 32'(b1.req_ready), 32'd1);
        check("rst/valid1", 32'(b1.rsp_valid), 32'd0);
        check("rst/rdata1", b1.rsp_rdata, 32'd0);
        check("rst/err1", 32'(b1.rsp_err), 32'd0);
        check("rst/ready3", 32'(b3.req_ready), 32'd1);
        check("rst/valid3", 32'(b3.rsp_valid), 32'd0);
        rst = 1'b0;

        req(0, "sw10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0);
        req(0, "lw10",  0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
        req(0, "sb11",  1, 2'b00, 0, 32'h11, 32'hAAAAAA80, 32'h0,        0);
        req(0, "lb11",  0, 2'b00, 0, 32'h11, 32'h0,        32'hFFFFFF80, 0);
        req(0, "lbu11", 0, 2'b00, 1, 32'h11, 32'h0,        32'h00000080, 0);
        req(0, "lw10b", 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEAD80EF, 0);
        req(0, "lh12",  0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFDEAD, 0);
        req(0, "lhu12", 0, 2'b01, 1, 32'h12, 32'h0,        32'h0000DEAD, 0);
        req(0, "lh13",  0, 2'b01, 0, 32'h13, 32'h0,        32'h0,        1);
        req(0, "sw12",  1, 2'b10, 0, 32'h12, 32'h12345678, 32'h0,        1);
        req(0, "lw10c", 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEAD80EF, 0);
        req(0, "lw100", 0, 2'b10, 0, 32'h100, 32'h0,       32'h0,        1);
        req(0, "sz11",  0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1);
        req(0, "sw100", 1, 2'b10, 0, 32'h100, 32'h5A5A5A5A, 32'h0,       1);
        req(0, "sw14",  1, 2'b10, 0, 32'h14, 32'h11223344, 32'h0,        0);
        req(0, "sh16",  1, 2'b01, 0, 32'h16, 32'hFFFF1234, 32'h0,        0);
        req(0, "lw14",  0, 2'b10, 0, 32'h14, 32'h0,        32'h12343344, 0);
        req(0, "lh14",  0, 2'b01, 0, 32'h14, 32'h0,        32'h00003344, 0);
        req(0, "lb17",  0, 2'b00, 0, 32'h17, 32'h0,        32'h00000012, 0);
        req(0, "swfc",  1, 2'b10, 0, 32'hFC, 32'h87654321, 32'h0,        0);
        req(0, "lhfe",  0, 2'b01, 0, 32'hFE, 32'h0,        32'hFFFF8765, 0);

        req(1, "sw20",  1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0);

        // u3 streaming: valid held high, accepts every LATENCY+1 cycles
        r_we = 1'b0; r_size = 2'b10; r_uns = 1'b0; r_addr = 32'h20;
        @(negedge clk);
        v3 = 1'b1;
        sb.push_back('{32'hCAFEF00D, 1'b0});
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("stream%0d/ready", k), 32'(b3.req_ready), 32'(k % 4 == 3));
            check($sformatf("stream%0d/valid", k), 32'(b3.rsp_valid), 32'(k % 4 == 3));
            if (b3.rsp_valid && sb.size() != 0) begin
                r = sb.pop_front();
                check($sformatf("stream%0d/rdata", k), b3.rsp_rdata, r.rdata);
                check($sformatf("stream%0d/err", k), 32'(b3.rsp_err), 32'(r.err));
            end
            if (k % 4 == 3) begin
                if (k == 11) v3 = 1'b0;
                else sb.push_back('{32'hCAFEF00D, 1'b0});
            end
        end
        sb.delete();

        req(1, "sw24", 1, 2'b10, 0, 32'h24, 32'h0BADC0DE, 32'h0, 0);

        // reset in the middle of a u3 load drops the response
        @(negedge clk);
        r_we = 1'b0; r_size = 2'b10; r_addr = 32'h24;
        v3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0;
        check("rstw/busy", 32'(b3.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rstw/ready", 32'(b3.req_ready), 32'd1);
        check("rstw/valid", 32'(b3.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("rstw/quiet%0d", k), 32'(b3.rsp_valid), 32'd0);
        end
        req(1, "lw24", 0, 2'b10, 0, 32'h24, 32'h0, 32'h0BADC0DE, 0);
        req(0, "lw10r", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
